// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared ASCII codes, parser state encoding, RGB colours and byte classifiers
package uart_cmd_pkg;

    localparam logic [7:0] ASCII_C  = 8'h43;
    localparam logic [7:0] ASCII_L  = 8'h4C;
    localparam logic [7:0] ASCII_P  = 8'h50;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;

    localparam logic [2:0] RGB_RED   = 3'b001;
    localparam logic [2:0] RGB_GREEN = 3'b010;
    localparam logic [2:0] RGB_BLUE  = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        GOT_CMD,
        GOT_ARG
    } state_t;

    function automatic logic is_term(input logic [7:0] b);
        return b == ASCII_CR || b == ASCII_LF;
    endfunction

    function automatic logic is_cmd(input logic [7:0] b);
        return b == ASCII_C || b == ASCII_L || b == ASCII_P;
    endfunction

    // C takes '0'..'7', L takes '0'/'1', P takes '1'..'9'
    function automatic logic arg_ok(input logic [7:0] c, input logic [7:0] a);
        return (c == ASCII_C && a >= ASCII_0 && a <= ASCII_0 + 8'd7) ||
               (c == ASCII_L && a >= ASCII_0 && a <= ASCII_0 + 8'd1) ||
               (c == ASCII_P && a >= ASCII_0 + 8'd1 && a <= ASCII_0 + 8'd9);
    endfunction

endpackage

// File: rtl/uart_cmd_parser_relay_pulse_timer.sv
// relay_pulse_timer: relay pulse down-counter, loaded with mult x PULSE_UNIT, strobes expire on its last cycle
//   clk, resetn : clock, asynchronous active-low reset
//   load        : start or restart a pulse of mult x PULSE_UNIT cycles
//   cancel      : abandon any running pulse
//   mult        : pulse length in PULSE_UNIT quanta (1..9)
//   expire      : high while the count is 1, so the owner can drop the relay on the 1->0 edge
module relay_pulse_timer #(
    parameter int PULSE_UNIT = 1_200_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       load,
    input  logic       cancel,
    input  logic [3:0] mult,
    output logic       expire
);
    localparam int W = $clog2(9 * PULSE_UNIT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cnt <= '0;
        else if (load)
            cnt <= W'(mult) * W'(PULSE_UNIT);
        else if (cancel)
            cnt <= '0;
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign expire = cnt == W'(1);

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles CMD/ARG/TERM ASCII frames from uart_rx and drives RGB and relay controls
//   clk, resetn : clock, asynchronous active-low reset
//   rxbyte      : received byte, qualified by received
//   received    : one-cycle byte strobe
//   rgb         : LED drive, bit0 red, bit1 green, bit2 blue
//   relay_on    : relay request, active-high
//   cmd_valid   : one-cycle pulse when a frame is applied
//   cmd_err     : one-cycle pulse on a rejected byte or an inter-byte timeout
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_200_000,
    parameter int PULSE_UNIT     = 1_200_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] rxbyte,
    input  logic       received,
    output logic [2:0] rgb,
    output logic       relay_on,
    output logic       cmd_valid,
    output logic       cmd_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state, state_nx;
    logic [7:0]    cmd;
    logic [3:0]    arg;
    logic [TW-1:0] tcnt;
    logic          latch_cmd, latch_arg, apply, err;
    logic          apply_l, apply_p, expire;

    always_comb begin
        state_nx  = state;
        latch_cmd = 1'b0;
        latch_arg = 1'b0;
        apply     = 1'b0;
        err       = 1'b0;
        if (received) begin
            case (state)
                IDLE: begin
                    latch_cmd = is_cmd(rxbyte);
                    err       = !is_cmd(rxbyte) && !is_term(rxbyte);
                    state_nx  = is_cmd(rxbyte) ? GOT_CMD : IDLE;
                end
                GOT_CMD: begin
                    latch_arg = arg_ok(cmd, rxbyte);
                    err       = !arg_ok(cmd, rxbyte);
                    state_nx  = arg_ok(cmd, rxbyte) ? GOT_ARG : IDLE;
                end
                GOT_ARG: begin
                    apply    = is_term(rxbyte);
                    err      = !is_term(rxbyte);
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end else if (state != IDLE && tcnt == TW'(TIMEOUT_CYCLES)) begin
            err      = 1'b1;
            state_nx = IDLE;
        end
    end

    assign apply_l = apply && cmd == ASCII_L;
    assign apply_p = apply && cmd == ASCII_P;

    relay_pulse_timer #(.PULSE_UNIT(PULSE_UNIT)) u_timer (
        .clk    (clk),
        .resetn (resetn),
        .load   (apply_p),
        .cancel (apply_l),
        .mult   (arg),
        .expire (expire)
    );

    // Only the low nibble of ARG is kept: '0'..'9' are 0x30..0x39, so it is the digit value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cmd       <= '0;
            arg       <= '0;
            tcnt      <= '0;
            rgb       <= RGB_RED;
            relay_on  <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            cmd_valid <= apply;
            cmd_err   <= err;
            tcnt      <= (received || state_nx == IDLE) ? '0 : tcnt + TW'(1);
            if (latch_cmd)
                cmd <= rxbyte;
            if (latch_arg)
                arg <= rxbyte[3:0];
            if (apply && cmd == ASCII_C)
                rgb <= arg[2:0];
            // an applied L or P overrides a pulse expiring in the same cycle
            if (apply_l)
                relay_on <= arg[0];
            else if (apply_p)
                relay_on <= 1'b1;
            else if (expire)
                relay_on <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: randomized and directed frames against a frame-level reference model with an event scoreboard
module tb_uart_cmd_parser;
    localparam int T  = 50;
    localparam int PU = 10;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       received = 1'b0;
    logic [7:0] rxbyte = 8'h00;
    logic [2:0] rgb;
    logic       relay_on, cmd_valid, cmd_err;

    always #5 clk = ~clk;

    uart_cmd_parser #(.TIMEOUT_CYCLES(T), .PULSE_UNIT(PU)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rxbyte    (rxbyte),
        .received  (received),
        .rgb       (rgb),
        .relay_on  (relay_on),
        .cmd_valid (cmd_valid),
        .cmd_err   (cmd_err)
    );

    typedef struct {
        int       cyc;
        bit       is_err;
        bit [2:0] rgb;
        bit       relay;
    } ev_t;

    ev_t evq[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  edge_n = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Reference model: frame buffer of up to two bytes, absolute pulse end time.
    int           flen;
    byte unsigned fcmd, farg;
    int           last;
    bit [2:0]     m_rgb;
    bit           m_relay;
    int           pulse_end;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
        end
    endtask

    task automatic model_reset();
        m_rgb = 3'b001;
        m_relay = 1'b0;
        flen = 0;
        pulse_end = -1;
        last = 0;
    endtask

    function automatic bit arg_valid(input byte unsigned c, input byte unsigned a);
        int d = int'(a) - 48;
        if (c == "C") return d >= 0 && d <= 7;
        if (c == "L") return d >= 0 && d <= 1;
        return d >= 1 && d <= 9;
    endfunction

    task automatic push(input int cyc, input bit is_err);
        evq.push_back('{cyc, is_err, m_rgb, m_relay});
    endtask

    task automatic model_edge(input int cyc, input bit s, input byte unsigned b);
        bit term = b == 8'h0D || b == 8'h0A;
        if (pulse_end == cyc) begin
            m_relay = 1'b0;
            pulse_end = -1;
        end
        if (s) begin
            last = cyc;
            if (flen == 0) begin
                if (b == "C" || b == "L" || b == "P") begin
                    fcmd = b;
                    flen = 1;
                end else if (!term)
                    push(cyc, 1'b1);
            end else if (flen == 1) begin
                if (arg_valid(fcmd, b)) begin
                    farg = b;
                    flen = 2;
                end else begin
                    flen = 0;
                    push(cyc, 1'b1);
                end
            end else begin
                flen = 0;
                if (term) begin
                    if (fcmd == "C") m_rgb = 3'(farg - 8'd48);
                    if (fcmd == "L") begin
                        m_relay = farg == "1";
                        pulse_end = -1;
                    end
                    if (fcmd == "P") begin
                        m_relay = 1'b1;
                        pulse_end = cyc + (int'(farg) - 48) * PU;
                    end
                    push(cyc, 1'b0);
                end else
                    push(cyc, 1'b1);
            end
        end else if (flen > 0 && cyc - last == T + 1) begin
            flen = 0;
            push(cyc, 1'b1);
        end
    endtask

    task automatic step(input bit s, input byte unsigned b);
        @(negedge clk);
        received = s;
        rxbyte = s ? b : 8'($urandom);
        model_edge(edge_n + 1, s, b);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00);
    endtask

    task automatic send(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            step(1'b1, s[i]);
            idle(gap);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        resetn = 1'b0;
        received = 1'b0;
        model_reset();
        repeat (n) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Monitor: levels every cycle, events popped from the scoreboard when the DUT pulses.
    initial begin
        ev_t e;
        forever begin
            @(posedge clk);
            #1;
            check("rgb", int'(rgb), int'(m_rgb));
            check("relay_on", int'(relay_on), int'(m_relay));
            while (evq.size() > 0 && evq[0].cyc < edge_n) begin
                e = evq.pop_front();
                check("missing_event_at", edge_n, e.cyc);
            end
            if (cmd_valid || cmd_err) begin
                if (evq.size() == 0)
                    check("unexpected_event", int'({cmd_err, cmd_valid}), 0);
                else begin
                    e = evq.pop_front();
                    check("event_edge", edge_n, e.cyc);
                    check("cmd_err", int'(cmd_err), int'(e.is_err));
                    check("cmd_valid", int'(cmd_valid), int'(!e.is_err));
                    check("event_rgb", int'(rgb), int'(e.rgb));
                    check("event_relay", int'(relay_on), int'(e.relay));
                end
            end
        end
    end

    initial begin
        byte unsigned alpha[16] = '{"C", "L", "P", "0", "1", "2", "3", "4", "5", "6", "7", "8", "9",
                                    8'h0D, 8'h0A, "X"};
        int r, g;
        model_reset();
        do_reset(3);
        idle(3);
        send("C4\015", 2);
        idle(5);
        send("L1\015\012", 1);
        send("L0\012", 0);
        idle(3);
        send("P3\015", 0);
        idle(40);
        send("P3\015", 0);
        idle(10);
        send("L1\015", 0);
        idle(40);
        send("L0\015", 0);
        send("X", 1);
        send("C9\015", 1);
        send("P0\015", 1);
        send("C1C", 1);
        send("\015", 1);
        send("C", 0);
        idle(55);
        send("2\015", 1);
        send("C", 0);
        idle(T);
        send("5\015", 0);
        send("C3", 0);
        idle(T + 1);
        send("\015", 1);
        send("P1\015", 0);
        send("L1", 0);
        idle(7);
        send("\015", 2);
        send("P2\015", 0);
        idle(PU * 2 - 3);
        send("P1\015", 0);
        idle(15);
        send("P5\015", 0);
        idle(5);
        send("L", 1);
        do_reset(2);
        send("C2\015", 1);
        idle(5);
        repeat (2500) begin
            r = $urandom_range(0, 9);
            step(1'b1, r < 3 ? alpha[$urandom_range(0, 2)] :
                       r < 7 ? alpha[$urandom_range(3, 12)] :
                       r < 9 ? alpha[$urandom_range(13, 14)] : alpha[15]);
            g = $urandom_range(0, 19);
            idle(g < 12 ? 0 : g < 18 ? $urandom_range(1, 5) : $urandom_range(T - 2, T + 3));
            if ($urandom_range(0, 499) == 0) do_reset(1);
        end
        idle(120);
        check("scoreboard_drained", evq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-level command parser that sits directly downstream of `uart_rx` and upstream of the RGB LED and relay drivers. It consumes the receiver's `rxbyte`/`received` strobe and assembles three-byte ASCII frames of the form command, argument, terminator. On a valid frame it updates registered RGB and relay controls, including a timed relay pulse mode. It flags malformed or timed-out frames.

## Interface
- `TIMEOUT_CYCLES`, 1_200_000: inter-byte timeout inside a frame (100 ms at 12 MHz).
- `PULSE_UNIT`, 1_200_000: relay pulse quantum in cycles; a pulse lasts arg × `PULSE_UNIT`.
- `clk`  in  1  system clock; the only clock.
- `resetn`  in  1  reset, asynchronous and active-low.
- `rxbyte`  in  8  received byte; valid only while `received`=1.
- `received`  in  1  one-cycle strobe from `uart_rx`.
- `rgb`  out  3  LED drive; bit0 red, bit1 green, bit2 blue.
- `relay_on`  out  1  relay request, active-high; inversion for active-low modules happens outside this block.
- `cmd_valid`  out  1  one-cycle pulse when a frame is applied.
- `cmd_err`  out  1  one-cycle pulse on a rejected byte, rejected frame or timeout.

## Operation
- Frame = CMD, ARG, TERM. TERM is 0x0D or 0x0A. Only uppercase command characters are accepted.
- Commands:
  - `C` with '0'..'7': `rgb` ← ARG−0x30.
  - `L` with '0'/'1': `relay_on` ← ARG bit 0; cancels any running pulse.
  - `P` with '1'..'9': `relay_on` ← 1; load pulse counter with ARG × `PULSE_UNIT`; a running pulse is restarted.
  - `P0` is an invalid argument.
- FSM states: IDLE, GOT_CMD, GOT_ARG.
  - IDLE: a valid CMD byte is latched and goes to GOT_CMD. 0x0D/0x0A are ignored silently, so CRLF and blank lines are tolerated. Any other byte pulses `cmd_err` and stays in IDLE.
  - GOT_CMD: an ARG valid for the latched CMD is latched and goes to GOT_ARG. Otherwise pulse `cmd_err` and return to IDLE.
  - GOT_ARG: TERM applies the command, pulses `cmd_valid` and returns to IDLE. Any other byte pulses `cmd_err` and returns to IDLE.
- A rejecting byte is discarded, never reinterpreted as a new CMD.
- Timeout: the counter clears on every `received` and runs only in GOT_CMD/GOT_ARG. When it reaches `TIMEOUT_CYCLES`, pulse `cmd_err` and go to IDLE.
- Pulse counter: decrements once per cycle while nonzero. On the transition 1→0, `relay_on` ← 0.
- Reset values: `rgb`=3'b001 (red), `relay_on`=0, `cmd_valid`=0, `cmd_err`=0, FSM=IDLE, all counters 0.

## Timing
- All outputs are registered.
- Apply latency: `rgb`, `relay_on` and `cmd_valid` all change on the first rising edge after the cycle in which the TERM strobe is sampled.
- `cmd_err` asserts on the edge after the offending strobe, or on the edge after the timeout count is reached.
- Back-to-back `received` strobes on consecutive cycles must be handled without loss.
- A strobe and a timeout in the same cycle: the strobe wins; the byte is processed and the counter is cleared.
- Pulse expiry in the same cycle as an applied `L1` or `P`: the applied command wins.
- `resetn` asserted mid-frame or mid-pulse forces the reset values immediately (asynchronous). The first byte after deassertion is parsed from IDLE.
- Counter widths:
  - timeout counter: $clog2(`TIMEOUT_CYCLES`+1);
  - pulse counter: $clog2(9×`PULSE_UNIT`+1).
  - The ARG × `PULSE_UNIT` product is computed at that width with no truncation.

## Structure
- Shared package `uart_cmd_pkg`:
  - ASCII constants for C, L, P, CR, LF, '0';
  - FSM state encoding;
  - RGB constants RED, GREEN, BLUE.
- One natural sub-module, `relay_pulse_timer`:
  - load/cancel inputs and the pulse counter;
  - outputs an `expire` strobe.
- Parser FSM, timeout counter and output registers stay in `uart_cmd_parser`.

## Test plan
- Reset release, then feed "C4\r" → `rgb` goes 3'b001→3'b100 one cycle after the CR strobe, with a single `cmd_valid` pulse and no `cmd_err`.
- "L1\r\n" then "L0\n" → `relay_on` 1 then 0. The LF after CR produces no `cmd_err`.
- `PULSE_UNIT`=10, "P3\r" → `relay_on` high for exactly 30 cycles after apply. Sending "L1\r" mid-pulse leaves it high with no expiry.
- Error bytes:
  - "X" → one `cmd_err`, FSM stays IDLE.
  - "C9\r" → `cmd_err` on '9'; the CR is ignored; `rgb` unchanged.
  - "P0\r" → `cmd_err`.
  - "C1C" → `cmd_err` on the second C, which is discarded.
- `TIMEOUT_CYCLES`=50: "C" then a 50-cycle idle gap → `cmd_err` and return to IDLE; a following "2\r" gives `cmd_err` on the '2' only.
- `resetn` pulsed low between "L" and "1" while a pulse is running → all outputs return to reset values; a subsequent "C2\r" applies normally.
